sram_port_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_resp_fifo.sv | 74 +++++++
 rtl/sram_port_ctrl.sv | 118 +++++++++++
 tb/tb_sram_port_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl_pkg
//  Brief    : Shared state encoding and response-buffer sizing for the
//             cache SRAM port controller.
//  Revision : 1.0
// ============================================================================
package sram_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned RESP_CNT_W = $clog2(RESP_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/sram_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sram_resp_fifo
//  Brief    : Small synchronous FIFO holding SRAM read data until consumed.
//  Revision : 1.0
// ============================================================================
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [RESP_CNT_W-1:0] o_count,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_head
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [WIDTH-1:0]      r_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [RESP_CNT_W-1:0] r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full   = (r_count == RESP_CNT_W'(RESP_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_do_pop = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + RESP_CNT_W'(1);
        2'b01:   r_count <= r_count - RESP_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) r_count <= RESP_CNT_W'(RESP_DEPTH));

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_ctrl
//  Brief    : Drives the single-port SRAM RW0 interface from a request stream,
//             zero-fills the array after reset and buffers read responses.
//  Revision : 1.0
// ============================================================================
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 256,
  parameter int MASK_W  = 32,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int unsigned OCC_W = RESP_CNT_W + 1;
  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(RESP_DEPTH);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_init_cnt;
  logic                  r_init_done;
  logic                  r_inflight;
  logic [RESP_CNT_W-1:0] w_count;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_fire;
  logic [OCC_W-1:0]      w_occ;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= INIT_EN ? ST_INIT : ST_RUN;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_fire && !req_write;
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + ADDR_W'(1);
          if (r_init_cnt == '1) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_init_done <= 1'b1;
      endcase
    end
  end

  // Credit counts buffered data plus the read still in the SRAM pipeline,
  // so a read is only issued when its response is guaranteed a slot.
  assign w_pop     = !w_empty && resp_ready;
  assign w_occ     = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign req_ready = !reset && r_init_done && (w_occ < C_DEPTH);
  assign w_fire    = req_valid && req_ready;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (!reset) begin
      if (r_state == ST_INIT) begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = r_init_cnt;
        RW0_wmask = '1;
      end else if (w_fire) begin
        RW0_en    = 1'b1;
        RW0_wmode = req_write;
        RW0_addr  = req_addr;
        RW0_wmask = req_wmask;
        RW0_wdata = req_wdata;
      end
    end
  end

  sram_resp_fifo #(
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk         (clock),
    .rst         (reset),
    .i_push      (r_inflight),
    .i_push_data (RW0_rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_head      (resp_rdata)
  );

  assign resp_valid = !w_empty;
  assign init_done  = r_init_done;

  a_no_en_in_reset: assert property (@(posedge clock) reset |-> !RW0_en);

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_ctrl
//  Brief    : Directed self-checking bench with a behavioural SRAM macro.
//  Revision : 1.0
// ============================================================================
module tb_sram_port_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LANE_W = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [MASK_W-1:0] req_wmask = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_port_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MASK_W  (MASK_W),
    .INIT_EN (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wmask  (RW0_wmask),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  // Behavioural single-port SRAM with one-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] sram_tmp;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= {8{32'hDEADBEEF}};
    rdata_q <= {8{32'hBAADF00D}};
  end

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        sram_tmp = mem[RW0_addr];
        for (int l = 0; l < MASK_W; l++)
          if (RW0_wmask[l]) sram_tmp[l*LANE_W +: LANE_W] = RW0_wdata[l*LANE_W +: LANE_W];
        mem[RW0_addr] <= sram_tmp;
      end else begin
        rdata_q <= mem[RW0_addr];
      end
    end
  end

  assign RW0_rdata = rdata_q;

  function automatic logic [DATA_W-1:0] pat(input int a);
    logic [31:0] w;
    w = {24'hC0FFEE, a[7:0]};
    return {8{w}};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a[ADDR_W-1:0];
    req_wdata = d;
    req_wmask = m;
    cyc();
    idle();
  endtask

  task automatic do_read(input int a, output logic rdy, output logic rv1,
                         output logic rv2, output logic [DATA_W-1:0] rd);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a[ADDR_W-1:0];
    @(negedge clock);
    rdy = req_ready;
    cyc();
    idle();
    @(negedge clock);
    rv1 = resp_valid;
    cyc();
    @(negedge clock);
    rv2 = resp_valid;
    rd  = resp_rdata;
    cyc();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clock);
    checks++;
    if (RW0_en !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_gating: en=%b ready=%b exp en=0 ready=0", RW0_en, req_ready);
    end
    checks++;
    if (init_done !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: init_done=%b resp_valid=%b exp 0 0", init_done, resp_valid);
    end
    checks++;
    if (RW0_addr !== '0 || RW0_wmode !== 1'b0 || RW0_wmask !== '0 || RW0_wdata !== '0) begin
      errors++;
      $display("FAIL reset_rw0_zero: addr=%h wmode=%b wmask=%h exp all 0", RW0_addr, RW0_wmode, RW0_wmask);
    end
    cyc();
    idle();
  endtask

  task automatic test_init();
    int bad;
    logic rdy, rv1, rv2;
    logic [DATA_W-1:0] rd;
    bad = 0;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_wmask === '1 && RW0_wdata === '0 &&
            RW0_addr === i[ADDR_W-1:0] && init_done === 1'b0 && req_ready === 1'b0)) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_sweep: bad_cycles=%0d exp 0", bad);
    end
    @(negedge clock);
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || RW0_en !== 1'b0) begin
      errors++;
      $display("FAIL init_done_513: init_done=%b ready=%b en=%b exp 1 1 0", init_done, req_ready, RW0_en);
    end
    cyc();
    do_read(32'h1A5, rdy, rv1, rv2, rd);
    checks++;
    if (rdy !== 1'b1 || rv2 !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL init_read_1a5: ready=%b valid=%b data=%h exp 1 1 0", rdy, rv2, rd);
    end
  endtask

  task automatic test_write_read();
    logic rdy, rv1, rv2;
    logic [DATA_W-1:0] rd;
    resp_ready = 1'b1;
    do_write(5, {32{8'hA5}}, '1);
    do_read(5, rdy, rv1, rv2, rd);
    checks++;
    if (rv1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_latency: resp_valid one cycle after fire=%b exp 0", rv1);
    end
    checks++;
    if (rv2 !== 1'b1 || rd !== {32{8'hA5}}) begin
      errors++;
      $display("FAIL wr_rd_data: valid=%b data=%h exp valid=1 data=%h", rv2, rd, {32{8'hA5}});
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_drained: resp_valid=%b exp 0", resp_valid);
    end
    cyc();
  endtask

  task automatic test_lane_mask();
    logic rdy, rv1, rv2;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] exp;
    exp = '1;
    exp[7:0] = 8'h00;
    do_write(7, '1, '1);
    do_write(7, '0, 32'h0000_0001);
    do_read(7, rdy, rv1, rv2, rd);
    checks++;
    if (rv2 !== 1'b1 || rd !== exp) begin
      errors++;
      $display("FAIL lane_mask: valid=%b data=%h exp %h", rv2, rd, exp);
    end
  endtask

  task automatic test_backpressure();
    int cur, fired, nresp, first, last, ord_bad, iss_bad, first_fire;
    logic fire_now;
    for (int a = 1; a <= 4; a++) do_write(a, pat(a), '1);
    resp_ready = 1'b0;
    cur = 1;
    fired = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = ADDR_W'(cur);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      fire_now = req_ready;
      if (fire_now) fired++;
      cyc();
      if (fire_now) begin
        cur++;
        req_addr = cur[ADDR_W-1:0];
      end
    end
    @(negedge clock);
    checks++;
    if (fired !== 2 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: fired=%0d ready=%b exp fired=2 ready=0", fired, req_ready);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== pat(1)) begin
      errors++;
      $display("FAIL bp_head: valid=%b data=%h exp 1 %h", resp_valid, resp_rdata, pat(1));
    end
    cyc();
    resp_ready = 1'b1;
    nresp = 0; first = -1; last = -1; ord_bad = 0; iss_bad = 0; first_fire = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      fire_now = req_valid && req_ready;
      if (fire_now) begin
        if (RW0_addr !== cur[ADDR_W-1:0]) iss_bad++;
        if (first_fire < 0) first_fire = c;
      end
      if (resp_valid) begin
        if (resp_rdata !== pat(nresp + 1)) ord_bad++;
        if (first < 0) first = c;
        last = c;
        nresp++;
      end
      cyc();
      if (fire_now) begin
        cur++;
        if (cur > 4) idle();
        else req_addr = cur[ADDR_W-1:0];
      end
    end
    checks++;
    if (first_fire !== 0) begin
      errors++;
      $display("FAIL bp_ready_comb: first fire cycle=%0d exp 0", first_fire);
    end
    checks++;
    if (cur !== 5 || iss_bad !== 0) begin
      errors++;
      $display("FAIL bp_issue: next_addr=%0d bad_addr=%0d exp 5 0", cur, iss_bad);
    end
    checks++;
    if (nresp !== 4 || ord_bad !== 0 || (last - first) !== 3) begin
      errors++;
      $display("FAIL bp_drain: nresp=%0d order_bad=%0d span=%0d exp 4 0 3", nresp, ord_bad, last - first);
    end
    idle();
  endtask

  task automatic test_throughput();
    int cur, notready, nresp, first, last, ord_bad;
    logic fire_now;
    for (int a = 16; a < 32; a++) do_write(a, pat(a), '1);
    resp_ready = 1'b1;
    cur = 16;
    notready = 0; nresp = 0; first = -1; last = -1; ord_bad = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = ADDR_W'(cur);
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      fire_now = req_valid && req_ready;
      if (req_valid && !req_ready) notready++;
      if (resp_valid) begin
        if (resp_rdata !== pat(16 + nresp)) ord_bad++;
        if (first < 0) first = c;
        last = c;
        nresp++;
      end
      cyc();
      if (fire_now) begin
        cur++;
        if (cur > 31) idle();
        else req_addr = cur[ADDR_W-1:0];
      end
    end
    checks++;
    if (notready !== 0) begin
      errors++;
      $display("FAIL tput_ready: stalled_cycles=%0d exp 0", notready);
    end
    checks++;
    if (nresp !== 16 || (last - first) !== 15) begin
      errors++;
      $display("FAIL tput_resp: nresp=%0d span=%0d exp 16 15", nresp, last - first);
    end
    checks++;
    if (ord_bad !== 0) begin
      errors++;
      $display("FAIL tput_order: bad=%0d exp 0", ord_bad);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int n;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = ADDR_W'(1);
    cyc();
    req_addr   = ADDR_W'(2);
    cyc();
    idle();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || RW0_en !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_sync: valid=%b en=%b ready=%b exp 1 0 0", resp_valid, RW0_en, req_ready);
    end
    cyc();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || RW0_en !== 1'b1 || RW0_addr !== '0) begin
      errors++;
      $display("FAIL run_reset_flush: valid=%b done=%b en=%b addr=%h exp 0 0 1 0",
               resp_valid, init_done, RW0_en, RW0_addr);
    end
    repeat (200) cyc();
    @(negedge clock);
    checks++;
    if (RW0_addr !== ADDR_W'(200)) begin
      errors++;
      $display("FAIL init_cnt_200: addr=%0d exp 200", RW0_addr);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n = 0;
    while (n < 600) begin
      @(negedge clock);
      if (n == 0) begin
        checks++;
        if (RW0_addr !== '0 || RW0_en !== 1'b1) begin
          errors++;
          $display("FAIL init_restart: addr=%0d en=%b exp 0 1", RW0_addr, RW0_en);
        end
      end
      if (init_done === 1'b1) break;
      n++;
      cyc();
    end
    checks++;
    if (n !== 512) begin
      errors++;
      $display("FAIL init_restart_len: cycles_before_done=%0d exp 512", n);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_discard: resp_valid=%b exp 0", resp_valid);
    end
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    test_reset();
    test_init();
    test_write_read();
    test_lane_mask();
    test_backpressure();
    test_throughput();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
